// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command FIFO and issue FSM for a combinational ALU.
// Commands are buffered, issued one at a time onto alu_oc/alu_a/alu_b, and the
// ALU result is captured one cycle later and held until accepted downstream.
// Divide-by-zero returns all ones with out_err set.
// Optional build macro: ALU_OP_STATS_EN adds the op_count/err_count counters.
module alu_op_issuer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_oc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       alu_oc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic [2:0]       out_oc,
  output logic             out_err,
  output logic [7:0]       op_count,
  output logic [7:0]       err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 3 + 2 * WIDTH;
  localparam logic [2:0]  OcDiv = 3'b011;

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty, push, pop, capture, release_out, div_zero;
  logic [2:0]       alu_oc_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, out_f_q;
  logic [2:0]       out_oc_q;
  logic             out_valid_q, out_err_q;

  // Ready depends only on the registered count, so a full FIFO never takes a
  // push even when the same cycle pops.
  assign in_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid && in_ready;
  assign div_zero = (alu_oc_q == OcDiv) && (alu_b_q == '0);

  // FIFO storage; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_oc, in_a, in_b};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          release_out = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand registers: load the FIFO head on a pop, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_oc_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else if (pop) begin
      {alu_oc_q, alu_a_q, alu_b_q} <= mem_q[rd_ptr_q];
    end
  end

  // Result capture and output hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_oc_q    <= '0;
      out_err_q   <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_oc_q    <= alu_oc_q;
      out_f_q     <= div_zero ? '1 : alu_f;
      out_err_q   <= div_zero;
    end else if (release_out) begin
      out_valid_q <= 1'b0;
    end
  end

  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_oc    = out_oc_q;
  assign out_err   = out_err_q;

`ifdef ALU_OP_STATS_EN
  logic [7:0] op_count_q, err_count_q;

  // Result and divide-by-zero counters, stepped on each output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q  <= '0;
      err_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      op_count_q <= op_count_q + 8'd1;
      if (out_err_q) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign op_count  = op_count_q;
  assign err_count = err_count_q;
`else
  assign op_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Command-buffering and issue stage that sits directly upstream of the combinational 4-bit ALU and also consumes its result. It accepts {opcode, a, b} commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU inputs, captures the ALU output one cycle later, and presents the result downstream over a valid/ready handshake. Divide-by-zero is detected and reported instead of passing an undefined quotient.

Parameters:
WIDTH, 4, operand/result width; matches the ALU datapath.
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command present on in_oc/in_a/in_b
in_ready  output  1  FIFO can accept a command this cycle
in_oc  input  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 not a, 101 xor, 110 or, 111 and)
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
alu_oc  output  3  opcode driven to the ALU
alu_a  output  WIDTH  operand a driven to the ALU
alu_b  output  WIDTH  operand b driven to the ALU
alu_f  input  WIDTH  ALU result, combinational from alu_oc/alu_a/alu_b
out_valid  output  1  result held on out_f/out_oc/out_err
out_ready  input  1  downstream accepts the result
out_f  output  WIDTH  captured result
out_oc  output  3  opcode that produced out_f
out_err  output  1  result is a divide-by-zero substitute
op_count  output  8  completed-result counter (see Optional Feature)
err_count  output  8  divide-by-zero counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; FSM goes to IDLE.
  - alu_oc/alu_a/alu_b = 0; out_valid = 0; out_f = 0; out_oc = 0; out_err = 0; counters = 0.
  - A command or result in flight at reset is discarded; no partial result is ever presented.
- FIFO:
  - Push on in_valid && in_ready. in_ready = !full, combinational from the registered count only.
  - When full, in_ready stays 0 even in a cycle where a pop occurs. There is no same-cycle push-through-full.
  - Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
  - Commands issue in strict FIFO order.
  - in_valid while in_ready = 0 is ignored; the command is not stored.
- Operand registers: alu_oc/alu_a/alu_b are registered. They change only on a pop and hold their value otherwise.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the operand registers and go to EXEC; else stay.
  - EXEC: one cycle for the ALU to settle. At the next edge:
    - out_f <= alu_f; out_oc <= alu_oc; out_err <= 0; out_valid <= 1; go to HOLD.
    - Exception: if alu_oc = 011 and alu_b = 0, out_f <= all ones, out_err <= 1, and alu_f is ignored.
  - HOLD: out_valid = 1 and outputs stay stable until out_ready = 1. On the edge with out_ready:
    - if FIFO non-empty: out_valid <= 0, pop into the operand registers, go to EXEC;
    - else: out_valid <= 0, go to IDLE.
- Latency: a command pushed at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1. out_valid rises after edge t+2.
- Throughput: with out_ready held at 1, one result every 2 cycles.
- Arithmetic: results are exactly alu_f, truncated to WIDTH by the ALU (add/sub/mul wrap). The block performs no arithmetic except the divide-by-zero substitution.
- Capacity: DEPTH commands in the FIFO plus 1 in EXEC/HOLD.

Optional Feature:
ALU_OP_STATS_EN
- Defined:
  - op_count increments by 1 on every result handshake (out_valid && out_ready).
  - err_count increments on every such handshake with out_err = 1.
  - Both are 8-bit, wrap 255 -> 0, and are cleared by reset.
- Not defined: op_count and err_count are tied to 0 and no counter flops are generated. All other behaviour is identical.

Test Plan:
- Push {000, 3, 5} with out_ready = 1 -> out_valid rises 2 edges after the push; out_f = 8, out_oc = 000, out_err = 0.
- Push {001, 2, 5}, then {010, 7, 3}, back to back, out_ready = 1 -> results in order: 4'hD, then 4'h5 (21 truncated); one result every 2 cycles.
- Push {011, 9, 0} -> out_f = 4'hF, out_err = 1. With ALU_OP_STATS_EN defined, err_count = 1 and op_count = 1 after the handshake.
- out_ready = 0, push 6 commands back to back -> 5 accepted; in_ready is 0 from the 6th attempt. out_valid is held with the first result stable. Releasing out_ready drains all 5 results in order.
- Assert rst_n = 0 while in HOLD with 3 queued commands -> immediately out_valid = 0, in_ready = 1, alu_* = 0. After release, no stale results appear.
- Divide {011, 12, 5} -> out_f = 2, out_err = 0; the non-zero divisor takes the normal path.
